sqrt_arbiter: RTL and testbench
===============================

# sqrt_arbiter

Shares one iterative, multi-cycle integer square-root engine between NREQ requesters, such as the weighing and dimension stations of the baggage-drop line.

- Arbitrates pending requests and latches the winner's radicand.
- Computes the root one result bit per clock with a restoring algorithm.
- Returns root, remainder and the winner's index with a one-cycle done pulse.
- Replaces per-station combinational square-root instances with a single sequenced engine.

## Interface

Parameters:
- NREQ, default 4: number of requesters, 2..8.
- W, default 8: radicand width; must be even.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NREQ: request per requester. Held high until that requester's done.
- radicand, input, NREQ*W: packed radicands. Requester i uses bits [i*W +: W]. Must be stable while its req is high.
- grant, output, NREQ: one-hot, registered. Marks the requester being served.
- busy, output, 1: high in ITER and DONE.
- done, output, 1: one-cycle pulse; root, rem and done_id are valid during it.
- done_id, output, clog2(NREQ): index of the served requester.
- root, output, W/2: floor(sqrt(radicand)).
- rem, output, W/2+1: radicand − root².

## Operation

States:
- IDLE:
  - req == 0: stay in IDLE.
  - req != 0: select a winner, latch its radicand into shift register d, set grant to the winner's one-hot, clear q, r and cnt, and go to ITER.
- ITER, one iteration per clock (restoring algorithm):
  - t = {r, d[W-1:W-2]} − {q, 2'b01}, evaluated in W/2+3 bits.
  - t ≥ 0: r ← t and q ← {q, 1}.
  - t < 0: r ← {r, d[W-1:W-2]} and q ← {q, 0}.
  - d shifts left by 2; cnt increments.
  - After W/2 iterations go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE. Clear grant on the same edge and update the arbitration pointer.

Rules:
- root = q and rem = r. Both are registered, stay stable after done, and update only at the next DONE.
- done_id equals the index of the grant bit and stays stable from grant until the next grant.
- Arbitration happens only in IDLE. Requests that arrive while busy wait.
- A requester that drops req mid-computation does not abort it. The result is still delivered with done and is simply unused.
- Changing radicand mid-computation has no effect, because the value was latched in IDLE.
- Radicand 0 is not special: root = 0, rem = 0, same latency.
- Reset mid-operation, on assertion, asynchronously:
  - forces IDLE;
  - clears grant, busy, done, done_id, root, rem, cnt and the pointer;
  - discards the operation; no done is issued for it.

## Timing

- Reset values: grant = 0, busy = 0, done = 0, done_id = 0, root = 0, rem = 0, pointer = 0, state IDLE.
- Edge E0: IDLE sees req != 0. grant and busy rise after E0.
- Edges E1..E(W/2): iterations. done rises after edge E(W/2), i.e. W/2 cycles after grant. With W = 8, done follows grant by 4 cycles.
- Edge E(W/2+1): done, busy and grant fall. State returns to IDLE.
- Back-to-back: if req != 0 in IDLE at edge E(W/2+2), the next grant follows immediately. Throughput is one result per W/2+2 cycles (6 for W = 8).
- done and grant are never high in IDLE.

## Configuration

Macro SQRT_ARB_ROUND_ROBIN_EN:
- Defined: round-robin arbitration.
  - The winner is the first set req bit searching upward from the pointer, wrapping from NREQ−1 to 0.
  - On DONE the pointer becomes (winner+1) mod NREQ.
  - This gives starvation-free service, with at most NREQ−1 other results ahead of any requester.
- Undefined: fixed priority. The lowest set req index always wins and the pointer logic is not built.

## Test plan

Defaults NREQ = 4, W = 8 for all scenarios.
- Single requester: req = 4'b0001 with radicand 200 → after 4 cycles, done pulse with root = 14, rem = 4, done_id = 0.
- Boundaries: radicands 0, 1, 144, 255 in turn →
  - 0 gives root 0, rem 0;
  - 1 gives root 1, rem 0;
  - 144 gives root 12, rem 0;
  - 255 gives root 15, rem 30;
  - each result arrives 4 cycles after its grant.
- Exhaustive: all 256 radicands on requester 2 → root² ≤ x < (root+1)², rem = x − root², done_id = 2 every time.
- Contention: req = 4'b1111 held, each requester reasserting req after its done →
  - with SQRT_ARB_ROUND_ROBIN_EN, done_id sequence is 0, 1, 2, 3, 0;
  - without it, done_id is 0 repeatedly;
  - back-to-back results are 6 cycles apart.
- Reset mid-ITER: assert reset 2 cycles after grant →
  - grant, busy and done drop immediately and no done is issued;
  - after reset release with req still high, a new grant goes to requester 0 and the full 4-cycle computation completes.
- Request dropped in ITER: req[1] falls 1 cycle after grant → done still pulses with done_id = 1 and the correct root; radicand changes during ITER are ignored.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Shared iterative restoring square-root engine, arbitrated among NREQ requesters.
// Define SQRT_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest request index wins.
module sqrt_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       radicand,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [W/2-1:0]          root,
  output logic [W/2:0]            rem
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned HW = W / 2;
  localparam int unsigned RW = HW + 1;
  localparam int unsigned TW = HW + 3;
  localparam int unsigned CW = $clog2(HW) + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic            busy_n, done_n;
  logic [IW-1:0]   done_id_n;
  logic [HW-1:0]   root_n, q, q_n;
  logic [RW-1:0]   rem_n, r, r_n;
  logic [W-1:0]    d, d_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   rd, t;
  logic [IW-1:0]   win;
  logic            found;

`ifdef SQRT_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]   ptr, ptr_n;
  int unsigned     idx;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_n;
  end
`else
  // Lowest pending request index wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[IW'(k)]) begin
        win   = IW'(k);
        found = 1'b1;
      end
    end
  end
`endif

  // Restoring trial subtraction: bring down two radicand bits, try subtracting 4q+1.
  always_comb begin
    rd = {r, d[W-1:W-2]};
    t  = rd - TW'({q, 2'b01});
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = 1'b0;
    done_id_n = done_id;
    root_n    = root;
    rem_n     = rem;
    d_n       = d;
    q_n       = q;
    r_n       = r;
    cnt_n     = cnt;
`ifdef SQRT_ARB_ROUND_ROBIN_EN
    ptr_n     = ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n   = ITER;
          grant_n   = NREQ'(1) << win;
          busy_n    = 1'b1;
          done_id_n = win;
          d_n       = radicand[win*W +: W];
          q_n       = '0;
          r_n       = '0;
          cnt_n     = '0;
        end
      end
      ITER: begin
        if (!t[TW-1]) begin
          r_n = RW'(t);
          q_n = HW'({q, 1'b1});
        end else begin
          r_n = RW'(rd);
          q_n = HW'({q, 1'b0});
        end
        d_n   = d << 2;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(HW - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          root_n  = q_n;
          rem_n   = r_n;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
`ifdef SQRT_ARB_ROUND_ROBIN_EN
        ptr_n   = (done_id == IW'(NREQ - 1)) ? '0 : done_id + IW'(1);
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      root    <= '0;
      rem     <= '0;
      d       <= '0;
      q       <= '0;
      r       <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      busy    <= busy_n;
      done    <= done_n;
      done_id <= done_id_n;
      root    <= root_n;
      rem     <= rem_n;
      d       <= d_n;
      q       <= q_n;
      r       <= r_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: transaction-level reference model checked every cycle, plus directed literal cases.
module tb_sqrt_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned HW   = W / 2;
  localparam int unsigned IW   = $clog2(NREQ);
`ifdef SQRT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   radicand;
  logic [NREQ-1:0]     grant;
  logic                busy, done;
  logic [IW-1:0]       done_id;
  logic [HW-1:0]       root;
  logic [HW:0]         rem;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  sqrt_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .radicand(radicand),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .root(root), .rem(rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int isqrt(int x);
    int s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  function automatic int pick(logic [NREQ-1:0] rq, int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = RR ? (p + k) % NREQ : k;
      if (rq[i]) return i;
    end
    return 0;
  endfunction

  // Reference model: phase 0 idle, 1..HW computing, HW+1 result cycle.
  int              m_phase, m_win, m_ptr, m_x, m_id, m_root, m_rem;
  logic [NREQ-1:0] m_grant;
  bit              m_busy, m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_root = 0; m_rem = 0;
      m_grant = '0; m_busy = 1'b0; m_done = 1'b0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        m_win   = pick(req, m_ptr);
        m_x     = int'(radicand[m_win*W +: W]);
        m_grant = NREQ'(1) << m_win;
        m_busy  = 1'b1;
        m_id    = m_win;
        m_phase = 1;
      end
    end else if (m_phase <= HW) begin
      if (m_phase == HW) begin
        m_done = 1'b1;
        m_root = isqrt(m_x);
        m_rem  = m_x - m_root * m_root;
      end
      m_phase++;
    end else begin
      m_done  = 1'b0;
      m_grant = '0;
      m_busy  = 1'b0;
      m_ptr   = (m_win + 1) % NREQ;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("grant",   grant,   m_grant);
    chk("busy",    busy,    m_busy);
    chk("done",    done,    m_done);
    chk("done_id", done_id, m_id);
    chk("root",    root,    m_root);
    chk("rem",     rem,     m_rem);
  end

  task automatic wait_grant(string nm);
    int n = 0;
    while (grant == '0 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_grant_timeout"}, 32'(n < 40), 1);
  endtask

  task automatic wait_done(string nm, output int n);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_done_timeout"}, done, 1);
  endtask

  task automatic run_one(int idx, int x, int er, int erem);
    int n;
    radicand[idx*W +: W] = W'(x);
    req[idx] = 1'b1;
    wait_grant("one");
    chk("one_grant", grant, 1 << idx);
    wait_done("one", n);
    chk("one_latency", n, HW);
    chk("one_root", root, er);
    chk("one_rem", rem, erem);
    chk("one_id", done_id, idx);
    chk("model_root", m_root, er);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last;
    reset = 1'b1; req = '0; radicand = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", done_id, 0);
    chk("rst_root", root, 0);
    chk("rst_rem", rem, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester and boundary radicands
    run_one(0, 200, 14, 4);
    run_one(0, 0, 0, 0);
    run_one(0, 1, 1, 0);
    run_one(0, 144, 12, 0);
    run_one(0, 255, 15, 30);

    // Every radicand on requester 2
    for (int x = 0; x < 256; x++) run_one(2, x, isqrt(x), x - isqrt(x) * isqrt(x));

    // Contention with all requests held; reset first so the pointer starts at 0
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) radicand[i*W +: W] = W'($urandom);
    req = '1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done("cont", n);
      chk("cont_id", done_id, RR ? k % NREQ : 0);
      if (k > 0) chk("cont_gap", cyc - last, HW + 2);
      last = cyc;
      radicand[done_id*W +: W] = W'($urandom);
      @(negedge clk);
    end
    req = '0;
    repeat (8) @(negedge clk);

    // Reset two cycles into the computation
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    radicand[0 +: W] = W'(50);
    radicand[W +: W] = W'(99);
    req = 4'b0011;
    wait_grant("rst");
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_grant("rst2");
    chk("rst2_grant", grant, 1);
    wait_done("rst2", n);
    chk("rst2_latency", n, HW);
    chk("rst2_id", done_id, 0);
    chk("rst2_root", root, 7);
    chk("rst2_rem", rem, 1);
    req[0] = 1'b0;
    @(negedge clk);
    wait_done("rst3", n);
    chk("rst3_id", done_id, 1);
    chk("rst3_root", root, 9);
    chk("rst3_rem", rem, 18);
    req = '0;
    @(negedge clk);

    // Request dropped and radicand changed during the computation
    radicand[W +: W] = W'(77);
    req = 4'b0010;
    wait_grant("drop");
    @(negedge clk);
    req[1] = 1'b0;
    radicand[W +: W] = W'(255);
    wait_done("drop", n);
    chk("drop_id", done_id, 1);
    chk("drop_root", root, 8);
    chk("drop_rem", rem, 13);
    @(negedge clk);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(399) == 0) reset = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && done && int'(done_id) == i) begin
          req[i] = 1'($urandom);
          radicand[i*W +: W] = W'($urandom);
        end else if (!req[i] && $urandom_range(3) == 0) begin
          radicand[i*W +: W] = W'($urandom);
          req[i] = 1'b1;
        end else if (grant[i] && busy && !done && $urandom_range(3) == 0) begin
          radicand[i*W +: W] = W'($urandom);
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
